dac_frame_gen: RTL and testbench

DAC_FRAME_GEN -- requirements
Module: dac_frame_gen

---
 rtl/dac_pkg.sv | 13 +
 rtl/dac_bit_timer.sv | 43 ++++
 rtl/dac_frame_gen.sv | 127 ++++++++++++
 tb/tb_dac_frame_gen.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_pkg.sv
// Shared types and default constants for the DAC serial frame generator.
package dac_pkg;

    typedef enum logic {
        FMT_I2S = 1'b0,
        FMT_LJ  = 1'b1
    } dac_format_t;

    localparam int DAC_WIDTH     = 24;
    localparam int DAC_SLOT_BITS = 24;
    localparam int DAC_BCLK_DIV  = 8;

endpackage

// File: rtl/dac_bit_timer.sv
// Bit-clock divider and frame bit counter; flags the last clk cycle of each frame.
module dac_bit_timer #(
    parameter int BCLK_DIV       = 8,
    parameter int BITS_PER_FRAME = 48,
    localparam int DW = $clog2(BCLK_DIV),
    localparam int BW = $clog2(BITS_PER_FRAME)
) (
    input  logic          clk,
    input  logic          rst,
    output logic [DW-1:0] div_cnt,
    output logic [BW-1:0] bit_idx,
    output logic          sclk,
    output logic          frame_end
);

    if (BCLK_DIV < 2 || (BCLK_DIV % 2) != 0) begin : g_bad_div
        $error("dac_bit_timer: BCLK_DIV must be even and >= 2");
    end
    if (BITS_PER_FRAME < 2) begin : g_bad_frame
        $error("dac_bit_timer: BITS_PER_FRAME must be >= 2");
    end

    logic div_last;
    logic bit_last;

    assign div_last  = (div_cnt == DW'(BCLK_DIV - 1));
    assign bit_last  = (bit_idx == BW'(BITS_PER_FRAME - 1));
    assign sclk      = (div_cnt >= DW'(BCLK_DIV / 2));
    assign frame_end = div_last && bit_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            bit_idx <= '0;
        end else if (div_last) begin
            div_cnt <= '0;
            bit_idx <= bit_last ? '0 : bit_idx + BW'(1);
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

endmodule

// File: rtl/dac_frame_gen.sv
// Serialises multichannel samples into I2S / left-justified / TDM frames.
// Optional saturating underrun counter port enabled by DAC_FRAME_UNDERRUN_CNT_EN.
module dac_frame_gen
    import dac_pkg::*;
#(
    parameter int          WIDTH     = DAC_WIDTH,
    parameter int          SLOT_BITS = DAC_SLOT_BITS,
    parameter int          CHANNELS  = 2,
    parameter int          BCLK_DIV  = DAC_BCLK_DIV,
    parameter dac_format_t FORMAT    = FMT_I2S
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic                      sclk,
    output logic                      lrclk,
    output logic                      sd,
    output logic                      sample_tick,
    output logic                      underrun
`ifdef DAC_FRAME_UNDERRUN_CNT_EN
    ,
    output logic [15:0]               underrun_cnt
`endif
);

    localparam int BITS = SLOT_BITS * CHANNELS;
    localparam int DW   = $clog2(BCLK_DIV);
    localparam int BW   = $clog2(BITS);

    if (WIDTH < 1 || SLOT_BITS < WIDTH) begin : g_bad_slot
        $error("dac_frame_gen: need 1 <= WIDTH <= SLOT_BITS");
    end
    if (CHANNELS < 2 || (CHANNELS % 2) != 0) begin : g_bad_ch
        $error("dac_frame_gen: CHANNELS must be even and >= 2");
    end
    if (BCLK_DIV < 2 || (BCLK_DIV % 2) != 0) begin : g_bad_div
        $error("dac_frame_gen: BCLK_DIV must be even and >= 2");
    end
    if (FORMAT != FMT_I2S && FORMAT != FMT_LJ) begin : g_bad_fmt
        $error("dac_frame_gen: FORMAT must be FMT_I2S or FMT_LJ");
    end

    logic [DW-1:0]             div_cnt;
    logic [BW-1:0]             bit_idx;
    logic                      frame_end;
    logic                      hold_full;
    logic [CHANNELS*WIDTH-1:0] hold_data;
    logic [BITS-1:0]           shreg;
    logic                      lj_prev;
    logic                      load;

    dac_bit_timer #(
        .BCLK_DIV      (BCLK_DIV),
        .BITS_PER_FRAME(BITS)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .div_cnt  (div_cnt),
        .bit_idx  (bit_idx),
        .sclk     (sclk),
        .frame_end(frame_end)
    );

    // Whole frame laid out MSB-first: slot 0 at the top, pad zeros after each sample.
    function automatic logic [BITS-1:0] format_frame(input logic [CHANNELS*WIDTH-1:0] smp);
        logic [BITS-1:0] f;
        f = '0;
        for (int s = 0; s < CHANNELS; s++) begin
            for (int b = 0; b < WIDTH; b++) begin
                f[BITS-1-(s*SLOT_BITS+b)] = smp[s*WIDTH+WIDTH-1-b];
            end
        end
        return f;
    endfunction

    assign in_ready    = !hold_full && !rst;
    assign sample_tick = frame_end && !rst;
    assign underrun    = frame_end && !hold_full && !rst;
    // A boundary frees the register in the same edge, so a write there is taken.
    assign load        = in_valid && (!hold_full || frame_end);

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_full <= 1'b0;
        end else begin
            hold_full <= load || (hold_full && !frame_end);
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            hold_data <= in_data;
        end
    end

    // Rotating rather than shifting restores the frame after BITS bits, so an underrun replays it.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg   <= '0;
            lj_prev <= 1'b0;
            sd      <= 1'b0;
            lrclk   <= 1'b0;
        end else if (frame_end) begin
            if (hold_full) begin
                shreg <= format_frame(hold_data);
            end
        end else if (div_cnt == '0) begin
            shreg   <= {shreg[BITS-2:0], shreg[BITS-1]};
            lj_prev <= shreg[BITS-1];
            sd      <= (FORMAT == FMT_LJ) ? shreg[BITS-1] : lj_prev;
            lrclk   <= (CHANNELS == 2) ? (bit_idx >= BW'(SLOT_BITS)) : (bit_idx == '0);
        end
    end

`ifdef DAC_FRAME_UNDERRUN_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            underrun_cnt <= '0;
        end else if (underrun && underrun_cnt != 16'hFFFF) begin
            underrun_cnt <= underrun_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dac_frame_gen.sv
// Randomised bench for dac_frame_gen: I2S, LJ and TDM instances against a slot/bit frame model.
module tb_dac_frame_gen;
    import dac_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_drv = 1'b1;
    int          cfg = 0;
    logic        rst0, rst1, rst2;
    logic        in_valid = 1'b0;
    logic [63:0] bus = '0;

    assign rst0 = rst_drv || (cfg != 0);
    assign rst1 = rst_drv || (cfg != 1);
    assign rst2 = rst_drv || (cfg != 2);

    logic rdy0, sclk0, lr0, sd0, tick0, und0;
    logic rdy1, sclk1, lr1, sd1, tick1, und1;
    logic rdy2, sclk2, lr2, sd2, tick2, und2;
`ifdef DAC_FRAME_UNDERRUN_CNT_EN
    logic [15:0] ucnt0, ucnt1, ucnt2, o_ucnt;
`endif

    dac_frame_gen d0 (
        .clk(clk), .rst(rst0), .in_data(bus[47:0]), .in_valid(in_valid), .in_ready(rdy0),
        .sclk(sclk0), .lrclk(lr0), .sd(sd0), .sample_tick(tick0), .underrun(und0)
`ifdef DAC_FRAME_UNDERRUN_CNT_EN
        , .underrun_cnt(ucnt0)
`endif
    );

    dac_frame_gen #(.FORMAT(FMT_LJ)) d1 (
        .clk(clk), .rst(rst1), .in_data(bus[47:0]), .in_valid(in_valid), .in_ready(rdy1),
        .sclk(sclk1), .lrclk(lr1), .sd(sd1), .sample_tick(tick1), .underrun(und1)
`ifdef DAC_FRAME_UNDERRUN_CNT_EN
        , .underrun_cnt(ucnt1)
`endif
    );

    dac_frame_gen #(.WIDTH(16), .SLOT_BITS(32), .CHANNELS(4), .BCLK_DIV(4)) d2 (
        .clk(clk), .rst(rst2), .in_data(bus), .in_valid(in_valid), .in_ready(rdy2),
        .sclk(sclk2), .lrclk(lr2), .sd(sd2), .sample_tick(tick2), .underrun(und2)
`ifdef DAC_FRAME_UNDERRUN_CNT_EN
        , .underrun_cnt(ucnt2)
`endif
    );

    logic o_rdy, o_sclk, o_lr, o_sd, o_tick, o_und;
    always_comb begin
        o_rdy = rdy0; o_sclk = sclk0; o_lr = lr0; o_sd = sd0; o_tick = tick0; o_und = und0;
`ifdef DAC_FRAME_UNDERRUN_CNT_EN
        o_ucnt = ucnt0;
`endif
        if (cfg == 1) begin
            o_rdy = rdy1; o_sclk = sclk1; o_lr = lr1; o_sd = sd1; o_tick = tick1; o_und = und1;
`ifdef DAC_FRAME_UNDERRUN_CNT_EN
            o_ucnt = ucnt1;
`endif
        end else if (cfg == 2) begin
            o_rdy = rdy2; o_sclk = sclk2; o_lr = lr2; o_sd = sd2; o_tick = tick2; o_und = und2;
`ifdef DAC_FRAME_UNDERRUN_CNT_EN
            o_ucnt = ucnt2;
`endif
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: frames held as one 32-bit word per channel.
    int W, SLOT, CH, DIV, LJ, BITS, F;
    int c, m_ucnt, last_tick, und_seen;
    bit m_full;
    logic [127:0] cur_f, prev_f, held_f;
    logic [127:0] cap_sd [4];
    logic [127:0] cap_lr [4];

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cfg %0d cycle %0d)", tag, obs, exp, cfg, c);
        end
    endtask

    function automatic logic [127:0] pack(input logic [63:0] b);
        logic [127:0] f;
        logic [63:0]  mask;
        f = '0;
        mask = (64'd1 << W) - 64'd1;
        for (int s = 0; s < CH; s++) f[s*32 +: 32] = 32'((b >> (s*W)) & mask);
        return f;
    endfunction

    function automatic logic lj_bit(input logic [127:0] f, input int p);
        int s, b;
        s = p / SLOT;
        b = p % SLOT;
        if (b >= W) return 1'b0;
        return f[s*32 + W - 1 - b];
    endfunction

    function automatic logic exp_sd(input int p);
        if (LJ != 0) return lj_bit(cur_f, p);
        if (p == 0) return lj_bit(prev_f, BITS - 1);
        return lj_bit(cur_f, p - 1);
    endfunction

    task automatic step();
        int ph, p, off;
        bit bnd, load;
        ph  = c % F;
        p   = ph / DIV;
        off = ph % DIV;
        bnd = (ph == F - 1);
        check_eq("sclk", 128'(o_sclk), 128'(off >= DIV / 2));
        check_eq("sample_tick", 128'(o_tick), 128'(bnd));
        check_eq("underrun", 128'(o_und), 128'(bnd && !m_full));
        check_eq("in_ready", 128'(o_rdy), 128'(!m_full));
`ifdef DAC_FRAME_UNDERRUN_CNT_EN
        check_eq("underrun_cnt", 128'(o_ucnt), 128'(m_ucnt));
`endif
        if (off == DIV / 2) begin
            check_eq("sd", 128'(o_sd), 128'(exp_sd(p)));
            check_eq("lrclk", 128'(o_lr), 128'((CH == 2) ? (p >= SLOT) : (p == 0)));
            if (c / F < 4) begin
                cap_sd[c/F][BITS-1-p] = o_sd;
                cap_lr[c/F][BITS-1-p] = o_lr;
            end
        end
        if (o_tick) begin
            if (last_tick < 0) check_eq("first_tick", 128'(c), 128'(F - 1));
            else check_eq("tick_period", 128'(c - last_tick), 128'(F));
            last_tick = c;
        end
        if (o_und) und_seen++;
        load = in_valid && (!m_full || bnd);
        if (bnd) begin
            if (!m_full && m_ucnt < 65535) m_ucnt++;
            prev_f = cur_f;
            if (m_full) cur_f = held_f;
            m_full = 1'b0;
        end
        if (load) begin
            held_f = pack(bus);
            m_full = 1'b1;
        end
        c++;
        @(negedge clk);
    endtask

    task automatic run_until(input int target, input int mode);
        while (c < target) begin
            if (mode == 1) begin
                in_valid = ($urandom_range(0, 299) == 0);
                bus = {$urandom, $urandom};
            end else begin
                in_valid = 1'b0;
            end
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic do_reset(input int k, input int cycles);
        rst_drv  = 1'b1;
        in_valid = 1'b0;
        cfg      = k;
        if (k == 2) begin
            W = 16; SLOT = 32; CH = 4; DIV = 4; LJ = 0;
        end else begin
            W = 24; SLOT = 24; CH = 2; DIV = 8; LJ = (k == 1) ? 1 : 0;
        end
        BITS = SLOT * CH;
        F    = BITS * DIV;
        repeat (cycles) @(negedge clk);
        check_eq("rst_sclk", 128'(o_sclk), 128'd0);
        check_eq("rst_lrclk", 128'(o_lr), 128'd0);
        check_eq("rst_sd", 128'(o_sd), 128'd0);
        check_eq("rst_tick", 128'(o_tick), 128'd0);
        check_eq("rst_underrun", 128'(o_und), 128'd0);
        check_eq("rst_in_ready", 128'(o_rdy), 128'd0);
`ifdef DAC_FRAME_UNDERRUN_CNT_EN
        check_eq("rst_underrun_cnt", 128'(o_ucnt), 128'd0);
`endif
        rst_drv = 1'b0;
        c = 0; m_full = 1'b0; m_ucnt = 0; last_tick = -1; und_seen = 0;
        cur_f = '0; prev_f = '0; held_f = '0;
        for (int i = 0; i < 4; i++) begin
            cap_sd[i] = '0;
            cap_lr[i] = '0;
        end
        #1;
        check_eq("ready_after_rst", 128'(o_rdy), 128'd1);
    endtask

    initial begin
        int target;

        // Default I2S stereo: known sample, then three starved frames.
        do_reset(0, 3);
        in_valid = 1'b1; bus = {16'h0, 24'h000001, 24'h800000};
        step();
        run_until(4 * F, 0);
        check_eq("i2s_frame1_sd", cap_sd[1], 128'h400000000000);
        check_eq("i2s_frame2_sd", cap_sd[2], 128'hC00000000000);
        check_eq("i2s_frame3_repeat", cap_sd[3], 128'hC00000000000);
        check_eq("i2s_frame1_lrclk", cap_lr[1], 128'h000000FFFFFF);
        check_eq("underrun_pulses", 128'(und_seen), 128'd3);
`ifdef DAC_FRAME_UNDERRUN_CNT_EN
        check_eq("underrun_cnt_3", 128'(o_ucnt), 128'd3);
`endif

        // Write arriving on a boundary while the register is still full.
        run_until(4 * F + 10, 0);
        in_valid = 1'b1; bus = {$urandom, $urandom};
        step();
        run_until(5 * F - 1, 0);
        in_valid = 1'b1; bus = {$urandom, $urandom};
        check_eq("collide_ready", 128'(o_rdy), 128'd0);
        step();
        in_valid = 1'b0;
        check_eq("collide_held", 128'(o_rdy), 128'd0);
        run_until(7 * F, 0);

        run_until(13 * F, 1);

        // Abort mid-frame at bit 20 with a sample pending.
        run_until(c + 5, 0);
        in_valid = 1'b1; bus = {$urandom, $urandom};
        step();
        target = (c / F + 1) * F + 20 * DIV + 3;
        run_until(target, 0);
        do_reset(0, 1);
        run_until(2 * F, 0);

        // Left-justified stereo.
        do_reset(1, 3);
        in_valid = 1'b1; bus = {16'h0, 24'h000001, 24'h800000};
        step();
        run_until(3 * F, 0);
        check_eq("lj_frame1_sd", cap_sd[1], 128'h800000000001);
        check_eq("lj_frame2_repeat", cap_sd[2], 128'h800000000001);
        check_eq("lj_frame1_lrclk", cap_lr[1], 128'h000000FFFFFF);
        run_until(6 * F, 1);

        // Four-slot TDM, 16-bit samples in 32-bit slots.
        do_reset(2, 3);
        in_valid = 1'b1; bus = {16'h0001, 16'h0000, 16'h0000, 16'hFFFF};
        step();
        run_until(2 * F, 0);
        check_eq("tdm_frame1_sd", cap_sd[1], 128'h7FFF8000_00000000_00000000_00008000);
        check_eq("tdm_frame1_lrclk", cap_lr[1], 128'h80000000_00000000_00000000_00000000);
        run_until(5 * F, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", c);
        $fatal(1);
    end

endmodule
